// File: rtl/ex_branch_unit_pkg.sv
// Shared decode constants, counter reset value and saturating helpers for the EX branch unit.
// The BRU_GSHARE_EN build option is consumed by ex_branch_unit; nothing here depends on it.
package ex_branch_unit_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [2:0] FNC_BEQ  = 3'b000;
    localparam logic [2:0] FNC_BNE  = 3'b001;
    localparam logic [2:0] FNC_BLT  = 3'b100;
    localparam logic [2:0] FNC_BGE  = 3'b101;
    localparam logic [2:0] FNC_BLTU = 3'b110;
    localparam logic [2:0] FNC_BGEU = 3'b111;

    // Weakly-not-taken: MSB clear, all lower bits set (01 for a 2-bit counter).
    `define BRU_CTR_RST(W) ({1'b0, {((W)-1){1'b1}}})

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

    function automatic logic [63:0] sat_dec(input logic [63:0] v);
        return (v == 64'd0) ? 64'd0 : v - 64'd1;
    endfunction

endpackage

// File: rtl/ex_branch_unit_bru_sat_table.sv
// Table of saturating direction counters: async reset, one training write port,
// one combinational lookup port with read-before-write behaviour.
module bru_sat_table
    import ex_branch_unit_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int CTR_WIDTH = 2,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [CTR_WIDTH-1:0] rd_ctr,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 wr_taken
);

    logic [CTR_WIDTH-1:0] ctr [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= `BRU_CTR_RST(CTR_WIDTH);
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                ctr[wr_idx] <= CTR_WIDTH'(sat_inc(64'(ctr[wr_idx]), CTR_WIDTH));
            end else begin
                ctr[wr_idx] <= CTR_WIDTH'(sat_dec(64'(ctr[wr_idx])));
            end
        end
    end

    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/ex_branch_unit.sv
// EX-stage branch resolution, flush/redirect generation, predictor training and perf counters.
// Optional macro BRU_GSHARE_EN adds a global history register and ex_ghr input (gshare indexing).
module ex_branch_unit
    import ex_branch_unit_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_WIDTH   = 2,
    parameter int PERF_WIDTH  = 32,
    parameter int HIST_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_pc,
    output logic                  if_pred_taken,
    input  logic                  ex_valid,
    input  logic                  ex_stall,
    input  logic [31:0]           ex_inst,
    input  logic [31:0]           ex_pc,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_target,
`ifdef BRU_GSHARE_EN
    input  logic [HIST_BITS-1:0]  ex_ghr,
`endif
    input  logic                  breq,
    input  logic                  brlt,
    output logic                  brun,
    output logic                  flush,
    output logic [31:0]           redirect_pc,
    output logic                  br_taken,
    input  logic                  perf_clr,
    output logic [PERF_WIDTH-1:0] perf_br_cnt,
    output logic [PERF_WIDTH-1:0] perf_mis_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [4:0]           opc5;
    logic [2:0]           funct3;
    logic                 is_br;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 fnc_ok;
    logic                 cond_taken;
    logic                 mispredict;
    logic                 train;
    logic [31:0]          pc_plus4;
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic [CTR_WIDTH-1:0] rd_ctr;
    logic                 unused_bits;

    assign opc5    = ex_inst[6:2];
    assign funct3  = ex_inst[14:12];
    assign is_br   = ex_valid && (opc5 == OPC_BRANCH);
    assign is_jal  = ex_valid && (opc5 == OPC_JAL);
    assign is_jalr = ex_valid && (opc5 == OPC_JALR);

    always_comb begin
        cond_taken = 1'b0;
        fnc_ok     = 1'b1;
        case (funct3)
            FNC_BEQ:            cond_taken = breq;
            FNC_BNE:            cond_taken = !breq;
            FNC_BLT, FNC_BLTU:  cond_taken = brlt;
            FNC_BGE, FNC_BGEU:  cond_taken = !brlt;
            default:            fnc_ok     = 1'b0;
        endcase
    end

    assign br_taken   = is_br && cond_taken;
    assign brun       = is_br && ((funct3 == FNC_BLTU) || (funct3 == FNC_BGEU));
    assign mispredict = is_br && (br_taken != ex_pred_taken);
    assign flush      = mispredict || is_jal || is_jalr;
    assign train      = is_br && fnc_ok && !ex_stall;
    assign pc_plus4   = ex_pc + 32'd4;

    // Purely a function of the held EX inputs, so a stall keeps it stable.
    always_comb begin
        redirect_pc = pc_plus4;
        if (is_jalr) begin
            redirect_pc = {ex_target[31:1], 1'b0};
        end else if (is_jal || (mispredict && br_taken)) begin
            redirect_pc = ex_target;
        end
    end

`ifdef BRU_GSHARE_EN
    logic [HIST_BITS-1:0] ghr;

    assign rd_idx = if_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign wr_idx = ex_pc[IDX_W+1:2] ^ IDX_W'(ex_ghr);

    // A mispredict rebuilds history from the fetch-time snapshot, discarding wrong-path bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (train) begin
            if (mispredict) begin
                ghr <= {ex_ghr[HIST_BITS-2:0], br_taken};
            end else begin
                ghr <= {ghr[HIST_BITS-2:0], br_taken};
            end
        end
    end
`else
    assign rd_idx = if_pc[IDX_W+1:2];
    assign wr_idx = ex_pc[IDX_W+1:2];
`endif

    bru_sat_table #(
        .ENTRIES   (BHT_ENTRIES),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (train),
        .wr_idx   (wr_idx),
        .wr_taken (br_taken)
    );

    assign if_pred_taken = rd_ctr[CTR_WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_br_cnt  <= '0;
            perf_mis_cnt <= '0;
        end else if (perf_clr) begin
            perf_br_cnt  <= '0;
            perf_mis_cnt <= '0;
        end else if (train) begin
            perf_br_cnt <= PERF_WIDTH'(sat_inc(64'(perf_br_cnt), PERF_WIDTH));
            if (mispredict) begin
                perf_mis_cnt <= PERF_WIDTH'(sat_inc(64'(perf_mis_cnt), PERF_WIDTH));
            end
        end
    end

    assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_inst[31:15], ex_inst[11:7], ex_inst[1:0]};

endmodule

// File: tb/tb_ex_branch_unit.sv
// Directed bench for ex_branch_unit: behavioural predictor/perf model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_ex_branch_unit;

    localparam logic [4:0] OP_BR   = 5'b11000;
    localparam logic [4:0] OP_JALR = 5'b11001;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic        breq;
    logic        brlt;
    logic        brun;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        br_taken;
    logic        perf_clr;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;

    ex_branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_stall      (ex_stall),
        .ex_inst       (ex_inst),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .breq          (breq),
        .brlt          (brlt),
        .brun          (brun),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_taken      (br_taken),
        .perf_clr      (perf_clr),
        .perf_br_cnt   (perf_br_cnt),
        .perf_mis_cnt  (perf_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mctr [64];
    int unsigned mbr;
    int unsigned mmis;

    // 1 = taken, 0 = not taken, -1 = not a defined conditional branch
    function automatic int resolve(input logic [2:0] f, input logic eq, input logic lt);
        case (f)
            3'b000:         return eq ? 1 : 0;
            3'b001:         return eq ? 0 : 1;
            3'b100, 3'b110: return lt ? 1 : 0;
            3'b101, 3'b111: return lt ? 0 : 1;
            default:        return -1;
        endcase
    endfunction

    function automatic logic live_br();
        return ex_valid && (ex_inst[6:2] == OP_BR);
    endfunction

    function automatic logic exp_taken();
        return live_br() && (resolve(ex_inst[14:12], breq, brlt) == 1);
    endfunction

    function automatic logic exp_brun();
        return live_br() && (ex_inst[14:13] == 2'b11);
    endfunction

    function automatic logic is_jump();
        return ex_valid && ((ex_inst[6:2] == OP_JAL) || (ex_inst[6:2] == OP_JALR));
    endfunction

    function automatic logic exp_flush();
        return (live_br() && (exp_taken() != ex_pred_taken)) || is_jump();
    endfunction

    function automatic logic [31:0] exp_redirect();
        if (ex_valid && ex_inst[6:2] == OP_JALR) return ex_target & 32'hFFFF_FFFE;
        if (ex_valid && ex_inst[6:2] == OP_JAL) return ex_target;
        if (live_br() && exp_taken() && !ex_pred_taken) return ex_target;
        return ex_pc + 32'd4;
    endfunction

    function automatic logic exp_pred();
        return mctr[if_pc[7:2]] >= 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mctr[i] <= 1;
            mbr  <= 0;
            mmis <= 0;
        end else begin
            if (live_br() && !ex_stall && resolve(ex_inst[14:12], breq, brlt) >= 0) begin
                if (resolve(ex_inst[14:12], breq, brlt) == 1) begin
                    if (mctr[ex_pc[7:2]] < 3) mctr[ex_pc[7:2]] <= mctr[ex_pc[7:2]] + 1;
                end else if (mctr[ex_pc[7:2]] > 0) begin
                    mctr[ex_pc[7:2]] <= mctr[ex_pc[7:2]] - 1;
                end
                mbr <= mbr + 1;
                if ((resolve(ex_inst[14:12], breq, brlt) == 1) != ex_pred_taken) mmis <= mmis + 1;
            end
            if (perf_clr) begin
                mbr  <= 0;
                mmis <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_pred",     {31'b0, if_pred_taken}, {31'b0, exp_pred()});
            check("m_taken",    {31'b0, br_taken},      {31'b0, exp_taken()});
            check("m_brun",     {31'b0, brun},          {31'b0, exp_brun()});
            check("m_flush",    {31'b0, flush},         {31'b0, exp_flush()});
            check("m_redirect", redirect_pc,            exp_redirect());
            check("m_perf_br",  perf_br_cnt,            mbr);
            check("m_perf_mis", perf_mis_cnt,           mmis);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred, input logic eq, input logic lt);
        ex_valid      = 1'b1;
        ex_inst       = {17'h0, f3, 5'h0, op, 2'b11};
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        breq          = eq;
        brlt          = lt;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_inst       = NOP;
        ex_pred_taken = 1'b0;
        breq          = 1'b0;
        brlt          = 1'b0;
    endtask

    initial begin
        rst = 1'b0; if_pc = 32'h100; ex_stall = 1'b0; perf_clr = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h0;
        idle();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();
        check("rst_flush",    {31'b0, flush}, 32'd0);
        check("rst_brun",     {31'b0, brun},  32'd0);
        check("rst_perf_br",  perf_br_cnt,    32'd0);
        check("rst_perf_mis", perf_mis_cnt,   32'd0);
        check("rst_pred",     {31'b0, if_pred_taken}, 32'd0);

        // BEQ taken, predicted not-taken
        drive(OP_BR, 3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
        #1;
        check("beq_flush",    {31'b0, flush}, 32'd1);
        check("beq_redirect", redirect_pc,    32'h140);
        check("beq_rbw_pred", {31'b0, if_pred_taken}, 32'd0);
        step(); idle(); #1;
        check("beq_pred_next", {31'b0, if_pred_taken}, 32'd1);
        check("beq_perf_br",   perf_br_cnt,  32'd1);
        check("beq_perf_mis",  perf_mis_cnt, 32'd1);

        // BNE not-taken predicted taken, four times on idx 0, then one taken
        if_pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            drive(OP_BR, 3'b001, 32'h200, 32'h280, 1'b1, 1'b1, 1'b0);
            #1;
            check("bne_flush",    {31'b0, flush}, 32'd1);
            check("bne_redirect", redirect_pc,    32'h204);
        end
        step(); drive(OP_BR, 3'b000, 32'h200, 32'h280, 1'b0, 1'b1, 1'b0);
        step(); idle(); #1;
        check("bne_floor_pred", {31'b0, if_pred_taken}, 32'd0);

        // JALR / JAL: flush and redirect, no training or counting
        step(); drive(OP_JALR, 3'b000, 32'h500, 32'h3001, 1'b0, 1'b0, 1'b0); #1;
        check("jalr_flush",    {31'b0, flush},    32'd1);
        check("jalr_redirect", redirect_pc,       32'h3000);
        check("jalr_taken",    {31'b0, br_taken}, 32'd0);
        step(); drive(OP_JAL, 3'b000, 32'h504, 32'h4002, 1'b0, 1'b1, 1'b0); #1;
        check("jal_redirect",  redirect_pc, 32'h4002);
        step(); idle(); #1;
        check("jump_perf_br",  perf_br_cnt,  32'd6);
        check("jump_perf_mis", perf_mis_cnt, 32'd6);

        // BLTU taken, held for three stalled edges
        if_pc = 32'h304;
        step();
        drive(OP_BR, 3'b110, 32'h304, 32'h380, 1'b0, 1'b0, 1'b1);
        ex_stall = 1'b1;
        #1;
        check("stall_brun0",  {31'b0, brun},  32'd1);
        check("stall_flush0", {31'b0, flush}, 32'd1);
        check("stall_redir0", redirect_pc,    32'h380);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            check("stall_brun",    {31'b0, brun},  32'd1);
            check("stall_flush",   {31'b0, flush}, 32'd1);
            check("stall_perf_br", perf_br_cnt,    32'd6);
            check("stall_pred",    {31'b0, if_pred_taken}, 32'd0);
        end
        step(); ex_stall = 1'b0; #1;
        check("stall_rel_flush", {31'b0, flush}, 32'd1);
        step(); idle(); #1;
        check("stall_perf_br",  perf_br_cnt,  32'd7);
        check("stall_perf_mis", perf_mis_cnt, 32'd7);
        check("stall_pred_upd", {31'b0, if_pred_taken}, 32'd1);

        // perf_clr wins over a counted branch
        step(); drive(OP_BR, 3'b101, 32'h308, 32'h3C0, 1'b1, 1'b0, 1'b0); perf_clr = 1'b1; #1;
        check("clr_flush", {31'b0, flush}, 32'd0);
        step(); idle(); perf_clr = 1'b0; #1;
        check("clr_perf_br",  perf_br_cnt,  32'd0);
        check("clr_perf_mis", perf_mis_cnt, 32'd0);

        // undefined funct3 with taken prediction
        step(); drive(OP_BR, 3'b010, 32'h30C, 32'h999, 1'b1, 1'b1, 1'b1); #1;
        check("undef_flush",    {31'b0, flush},    32'd1);
        check("undef_redirect", redirect_pc,       32'h310);
        check("undef_taken",    {31'b0, br_taken}, 32'd0);
        step(); idle(); #1;
        check("undef_perf_br", perf_br_cnt, 32'd0);

        // five taken updates to idx 3, then asynchronous reset
        if_pc = 32'h30C;
        for (int i = 0; i < 5; i++) begin
            step(); drive(OP_BR, 3'b000, 32'h30C, 32'h300, 1'b1, 1'b1, 1'b0);
        end
        step(); idle(); #1;
        check("sat_pred",    {31'b0, if_pred_taken}, 32'd1);
        check("sat_perf_br", perf_br_cnt, 32'd5);
        #1 rst = 1'b1;
        #1;
        check("arst_pred",     {31'b0, if_pred_taken}, 32'd0);
        check("arst_perf_br",  perf_br_cnt,  32'd0);
        check("arst_perf_mis", perf_mis_cnt, 32'd0);
        step();
        #2 rst = 1'b0;

        // mixed conditional branches checked by the model
        step(); drive(OP_BR, 3'b100, 32'h410, 32'h500, 1'b1, 1'b0, 1'b1);
        step(); drive(OP_BR, 3'b100, 32'h414, 32'h500, 1'b1, 1'b0, 1'b0);
        step(); drive(OP_BR, 3'b111, 32'h418, 32'h600, 1'b0, 1'b0, 1'b0);
        step(); drive(OP_BR, 3'b111, 32'h41C, 32'h600, 1'b0, 1'b0, 1'b1);
        step(); drive(OP_BR, 3'b001, 32'h420, 32'h700, 1'b0, 1'b0, 1'b0);
        step(); drive(OP_BR, 3'b011, 32'h424, 32'h700, 1'b0, 1'b1, 1'b1);
        if_pc = 32'h418;
        step(); idle();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
